// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer
//   Two-entry valid/ready stage (main + skid register) that sits ahead of a
//   register bank. in_ready, out_valid and out_data all come straight from
//   flops. No combinational path runs from in_* to out_* or from out_ready
//   to in_ready.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1 (in_fire = in_valid & in_ready, out_fire = out_valid & out_ready).
//   The producer may raise or drop valid at any time. While out_valid=1 and
//   out_ready=0, out_valid and out_data hold steady.
//
//   The state encoding equals the entry count, so occupancy is the live FSM
//   state. Debug logic can bind to it directly.
module pipe_skid_buffer #(
   parameter int SIZE      = 1,
   parameter int BIT_WIDTH = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              flush,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [SIZE-1:0][BIT_WIDTH-1:0]    in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [SIZE-1:0][BIT_WIDTH-1:0]    out_data,
   output logic [1:0]                        occupancy
);

   // Encoding doubles as the entry count (0..2). The value 3 is never produced.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [SIZE-1:0][BIT_WIDTH-1:0] main_q;
   logic [SIZE-1:0][BIT_WIDTH-1:0] skid_q;

   logic in_fire;
   logic out_fire;
   logic load_main_in;
   logic load_main_skid;
   logic load_skid_in;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Next-state and register-load decode. Ready and valid depend only on
   // the registered state.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      in_ready       = (state_q != FULL);
      out_valid      = (state_q != EMPTY);
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               load_main_in = 1'b1;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (in_fire) begin
               load_skid_in = 1'b1;
               state_d      = FULL;
            end else if (out_fire) begin
               state_d      = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so only the consumer can move things.
            if (out_fire) begin
               load_main_skid = 1'b1;
               state_d        = BUSY;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // State register: reset beats flush, and flush beats the handshake update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= EMPTY;
      end else if (flush) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Data registers are cleared on reset. On flush they keep stale contents,
   // which stay hidden because out_valid drops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else if (!flush) begin
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid_in) begin
            skid_q <= in_data;
         end
      end
   end

   assign out_data  = main_q;
   assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer
//   The driver process applies directed then random stimulus just after each
//   rising edge. The monitor process samples at the falling edge. It keeps a
//   FIFO model (exp_q) of accepted payloads, pushes on in_fire, pops on
//   out_fire and clears on reset or flush. Every cycle it compares the DUT
//   against that model.
module tb_pipe_skid_buffer;
   localparam int SIZE = 2;
   localparam int BW   = 4;
   localparam int W    = SIZE * BW;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     flush;
   logic                     in_valid;
   logic                     in_ready;
   logic [SIZE-1:0][BW-1:0]  in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [SIZE-1:0][BW-1:0]  out_data;
   logic [1:0]               occupancy;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;

   pipe_skid_buffer #(.SIZE(SIZE), .BIT_WIDTH(BW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard / monitor
   bit           live      = 1'b0;
   bit           rst_seen  = 1'b0;
   bit           hold_prev = 1'b0;
   logic [W-1:0] hold_data;

   always @(negedge clk) begin
      if (live) begin
         check("occupancy", 32'(occupancy), 32'(exp_q.size()));
         check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         check("in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
         if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
         if (rst_seen) check("reset_data", 32'(out_data), 32'd0);
         if (hold_prev) begin
            check("stable_valid", 32'(out_valid), 32'd1);
            check("stable_data",  32'(out_data),  32'(hold_data));
         end
      end
      // Predict the effect of the coming rising edge.
      rst_seen  = 1'b0;
      hold_prev = 1'b0;
      if (reset === 1'b0) begin
         exp_q.delete();
         live     = 1'b1;
         rst_seen = 1'b1;
      end else if (live) begin
         if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         if (flush) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back(in_data);
         hold_prev = out_valid && !out_ready && !flush;
         hold_data = out_data;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         tick();
      end
      check("send_accepted", 32'(done), 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      // reset held for two edges with junk on the input
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = '1;
      out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      @(negedge clk);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_rdy", 32'(in_ready), 32'd1);
      tick();

      // streaming
      out_ready = 1'b1;
      send(W'(8'h01));
      send(W'(8'h02));
      send(W'(8'h03));
      repeat (2) tick();

      // backpressure
      out_ready = 1'b0;
      send(W'(8'h0A));
      send(W'(8'h0B));
      repeat (3) tick();
      @(negedge clk);
      check("bp_occ",  32'(occupancy), 32'd2);
      check("bp_rdy",  32'(in_ready),  32'd0);
      check("bp_data", 32'(out_data),  32'h0A);
      tick();
      out_ready = 1'b1;
      repeat (4) tick();

      // flush while FULL, with a coincident input that must be discarded
      out_ready = 1'b0;
      send(W'(8'h0A));
      send(W'(8'h0B));
      in_valid = 1'b1;
      in_data  = W'(8'h0C);
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("fl_occ",   32'(occupancy), 32'd0);
      check("fl_valid", 32'(out_valid), 32'd0);
      check("fl_rdy",   32'(in_ready),  32'd1);
      tick();
      out_ready = 1'b1;
      repeat (5) tick();

      // random traffic with occasional flush and reset
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0) ^ (i[9] & i[8]);
         flush     = ($urandom_range(0, 99) == 0);
         reset     = ($urandom_range(0, 499) != 0);
         tick();
      end
      flush     = 1'b0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
